// File: rtl/sound_mixer_i2s.sv
// Mono mixer for the cartridge sound sources: one multiply-accumulate per CLK once per audio frame,
// saturated to the output width and sent to an external DAC as I2S (same word in both slots).
module sound_mixer_i2s #(
    parameter int CH_COUNT  = 4,
    parameter int IN_WIDTH  = 16,
    parameter int VOL_WIDTH = 4,
    parameter int OUT_WIDTH = 16,
    parameter int BCLK_HALF = 8
) (
    input  logic                          RESET_n,
    input  logic                          CLK,
    input  logic [CH_COUNT*IN_WIDTH-1:0]  IN,
    input  logic [CH_COUNT*VOL_WIDTH-1:0] VOL,
    input  logic                          MUTE,
    output logic [OUT_WIDTH-1:0]          MIX_OUT,
    output logic                          MIX_STB,
    output logic                          CLIP,
    output logic                          I2S_BCLK,
    output logic                          I2S_LRCK,
    output logic                          I2S_SDATA,
    output logic [1:0]                    DBG_STATE
);

    localparam int ACC_W  = IN_WIDTH + VOL_WIDTH + $clog2(CH_COUNT) + 1;
    localparam int PROD_W = IN_WIDTH + VOL_WIDTH + 1;
    localparam int SAT_W  = (ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH + 1;
    localparam int CH_W   = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
    localparam int DIV_W  = $clog2(BCLK_HALF);
    localparam int B_W    = $clog2(2 * OUT_WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
    localparam logic [B_W-1:0]   B_LAST   = B_W'(2 * OUT_WIDTH - 1);
    localparam logic [B_W-1:0]   B_HALF   = B_W'(OUT_WIDTH);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH_COUNT - 1);
    localparam logic signed [SAT_W-1:0] OUT_MAX = SAT_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [SAT_W-1:0] OUT_MIN = ~OUT_MAX;

    if (CH_COUNT < 1 || CH_COUNT > 8) begin : g_bad_ch_count
        $error("sound_mixer_i2s: CH_COUNT must be 1..8");
    end
    if (BCLK_HALF < 2) begin : g_bad_bclk_half
        $error("sound_mixer_i2s: BCLK_HALF must be >= 2");
    end
    // The mix pass must finish well inside one frame, so a frame start never lands outside IDLE.
    if (!(4 * OUT_WIDTH * BCLK_HALF > CH_COUNT + 3)) begin : g_bad_frame_len
        $error("sound_mixer_i2s: frame too short for the mix pass");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SAT  = 2'd2
    } state_t;

    // Bit clock, slot bit counter and serialiser state
    logic [DIV_W-1:0]     div_q;
    logic                 bclk_q;
    logic [B_W-1:0]       b_q;
    logic [B_W-1:0]       b_d;
    logic                 lrck_q;
    logic                 sdata_q;
    logic [OUT_WIDTH-1:0] w_q;
    logic [OUT_WIDTH-1:0] w_prev_q;
    logic [OUT_WIDTH-1:0] sh_q;
    logic                 bclk_fall;
    logic                 fs;

    // Mix pass state
    state_t                         state_q;
    logic [CH_W-1:0]                ch_q;
    logic signed [ACC_W-1:0]        acc_q;
    logic signed [ACC_W-1:0]        acc_d;
    logic [CH_COUNT*IN_WIDTH-1:0]   in_snap_q;
    logic [CH_COUNT*VOL_WIDTH-1:0]  vol_snap_q;
    logic signed [PROD_W-1:0]       prod;
    logic signed [SAT_W-1:0]        sat_in;
    logic [OUT_WIDTH-1:0]           mix_q;
    logic                           stb_q;
    logic                           clip_q;

    assign bclk_fall = bclk_q && (div_q == DIV_LAST);
    assign fs        = bclk_fall && (b_q == B_LAST);
    assign b_d       = (b_q == B_LAST) ? '0 : b_q + 1'b1;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q  <= '0;
            bclk_q <= ~bclk_q;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // The shift register walks W MSB-first through each slot and is reloaded at both slot
    // boundaries; the slot's last bit goes out one BCLK late (I2S delay), hence the W_prev copy.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            b_q      <= '0;
            lrck_q   <= 1'b0;
            sdata_q  <= 1'b0;
            w_q      <= '0;
            w_prev_q <= '0;
            sh_q     <= '0;
        end else if (bclk_fall) begin
            b_q    <= b_d;
            lrck_q <= (b_d >= B_HALF);
            if (fs) begin
                sdata_q <= w_prev_q[0];
                w_q     <= mix_q;
                sh_q    <= mix_q;
            end else if (b_d == B_HALF) begin
                sdata_q  <= sh_q[OUT_WIDTH-1];
                sh_q     <= w_q;
                w_prev_q <= w_q;
            end else begin
                sdata_q <= sh_q[OUT_WIDTH-1];
                sh_q    <= sh_q << 1;
            end
        end
    end

    // Channel 0 always sits in the low bits of the snapshots; they shift down one channel per ACC cycle.
    assign prod   = $signed(in_snap_q[IN_WIDTH-1:0]) * $signed({1'b0, vol_snap_q[VOL_WIDTH-1:0]});
    assign acc_d  = acc_q + ACC_W'(prod);
    assign sat_in = SAT_W'(acc_q >>> (VOL_WIDTH - 1));

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            acc_q      <= '0;
            in_snap_q  <= '0;
            vol_snap_q <= '0;
            mix_q      <= '0;
            stb_q      <= 1'b0;
            clip_q     <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fs) begin
                        in_snap_q  <= MUTE ? '0 : IN;
                        vol_snap_q <= VOL;
                        acc_q      <= '0;
                        ch_q       <= '0;
                        state_q    <= ACC;
                    end
                end
                ACC: begin
                    acc_q      <= acc_d;
                    in_snap_q  <= in_snap_q >> IN_WIDTH;
                    vol_snap_q <= vol_snap_q >> VOL_WIDTH;
                    ch_q       <= ch_q + 1'b1;
                    if (ch_q == CH_LAST) begin
                        state_q <= SAT;
                    end
                end
                SAT: begin
                    stb_q   <= 1'b1;
                    state_q <= IDLE;
                    if (sat_in > OUT_MAX) begin
                        mix_q  <= OUT_MAX[OUT_WIDTH-1:0];
                        clip_q <= 1'b1;
                    end else if (sat_in < OUT_MIN) begin
                        mix_q  <= OUT_MIN[OUT_WIDTH-1:0];
                        clip_q <= 1'b1;
                    end else begin
                        mix_q  <= sat_in[OUT_WIDTH-1:0];
                        clip_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MIX_OUT   = mix_q;
    assign MIX_STB   = stb_q;
    assign CLIP      = clip_q;
    assign I2S_BCLK  = bclk_q;
    assign I2S_LRCK  = lrck_q;
    assign I2S_SDATA = sdata_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_sound_mixer_i2s.sv
// Bench for sound_mixer_i2s: a frame-level model (cycle count -> bit position, one mix per frame)
// is compared with every output each cycle; directed cases pin the model with literal values.
module tb_sound_mixer_i2s;

    localparam int CH    = 4;
    localparam int INW   = 16;
    localparam int VW    = 4;
    localparam int OW    = 16;
    localparam int BH    = 8;
    localparam int FRAME = 4 * OW * BH;

    // ---------------- clock / reset ----------------
    logic CLK     = 1'b0;
    logic RESET_n = 1'b1;
    always #5 CLK = ~CLK;

    logic [CH*INW-1:0] in_bus   = '0;
    logic [CH*VW-1:0]  vol_bus  = '0;
    logic              mute     = 1'b0;
    logic [OW-1:0]     mix_out;
    logic              mix_stb;
    logic              clip;
    logic              bclk;
    logic              lrck;
    logic              sdata;
    logic [1:0]        dbg_state;

    sound_mixer_i2s #(
        .CH_COUNT(CH), .IN_WIDTH(INW), .VOL_WIDTH(VW), .OUT_WIDTH(OW), .BCLK_HALF(BH)
    ) dut (
        .RESET_n(RESET_n), .CLK(CLK), .IN(in_bus), .VOL(vol_bus), .MUTE(mute),
        .MIX_OUT(mix_out), .MIX_STB(mix_stb), .CLIP(clip),
        .I2S_BCLK(bclk), .I2S_LRCK(lrck), .I2S_SDATA(sdata), .DBG_STATE(dbg_state)
    );

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_mix(input logic [CH*INW-1:0] ins, input logic [CH*VW-1:0] vols,
                                      input logic m, output logic [OW-1:0] r, output logic c);
        longint sum = 0;
        longint s;
        longint maxv = (longint'(1) <<< (OW - 1)) - 1;
        longint minv = -(longint'(1) <<< (OW - 1));
        for (int ch = 0; ch < CH; ch++) begin
            sum += longint'($signed(ins[ch*INW +: INW])) * longint'(vols[ch*VW +: VW]);
        end
        if (m) sum = 0;
        s = sum >>> (VW - 1);
        c = 1'b0;
        if (s > maxv) begin s = maxv; c = 1'b1; end
        if (s < minv) begin s = minv; c = 1'b1; end
        r = s[OW-1:0];
    endfunction

    int            n = 0;
    logic [OW-1:0] cur_mix = '0;
    logic          cur_clip = 1'b0;
    logic          stb_exp = 1'b0;
    logic [OW-1:0] w = '0;
    logic [OW-1:0] wprev = '0;
    logic [OW:0]   exp_q[$];
    int            due_q[$];

    always @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            n = 0; cur_mix = '0; cur_clip = 1'b0; stb_exp = 1'b0;
            w = '0; wprev = '0;
            exp_q.delete(); due_q.delete();
        end else begin
            logic [OW-1:0] r;
            logic          c;
            logic [OW:0]   e;
            n++;
            stb_exp = 1'b0;
            if (due_q.size() > 0 && due_q[0] == n) begin
                e = exp_q.pop_front();
                void'(due_q.pop_front());
                cur_clip = e[OW];
                cur_mix  = e[OW-1:0];
                stb_exp  = 1'b1;
            end
            if (n % FRAME == 0) begin
                wprev = w;
                w     = cur_mix;
                model_mix(in_bus, vol_bus, mute, r, c);
                exp_q.push_back({c, r});
                due_q.push_back(n + CH + 1);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        if (chk_en) begin
            int b;
            int idx;
            logic e_sd;
            b    = (n / (2 * BH)) % (2 * OW);
            idx  = (b <= OW) ? OW - b : 2 * OW - b;
            e_sd = (b == 0) ? wprev[0] : w[idx];
            check("bclk",    bclk,    64'((n / BH) % 2));
            check("lrck",    lrck,    64'(b >= OW));
            check("sdata",   sdata,   64'(e_sd));
            check("mix_out", mix_out, 64'(cur_mix));
            check("mix_stb", mix_stb, 64'(stb_exp));
            check("clip",    clip,    64'(cur_clip));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_ch(input int ch, input logic [INW-1:0] s, input logic [VW-1:0] v);
        in_bus[ch*INW +: INW] = s;
        vol_bus[ch*VW +: VW]  = v;
    endtask

    task automatic clear_all();
        in_bus = '0; vol_bus = '0; mute = 1'b0;
    endtask

    task automatic wait_stb();
        bit got = 0;
        for (int k = 0; k < 2 * FRAME + 16 && !got; k++) begin
            @(negedge CLK);
            if (mix_stb) got = 1;
        end
        if (!got) check("stb_timeout", 0, 1);
    endtask

    task automatic wait_phase(input int p);
        bit got = 0;
        for (int k = 0; k < 2 * FRAME + 16 && !got; k++) begin
            @(negedge CLK);
            if (n % FRAME == p) got = 1;
        end
        if (!got) check("phase_timeout", 0, 1);
    endtask

    task automatic expect_mix(input string name, input logic [OW-1:0] m, input logic c);
        wait_stb();
        check({name, "_mix"}, mix_out, 64'(m));
        check({name, "_clip"}, clip, 64'(c));
    endtask

    task automatic capture_frame(output logic [OW-1:0] left, output logic [OW-1:0] right,
                                 output int bclk_period);
        logic prev_l;
        logic prev_b;
        bit   got = 0;
        int   cnt = 0;
        int   r1 = 0;
        int   r2 = 0;
        left = '0; right = '0;
        prev_l = lrck;
        for (int k = 0; k < 2 * FRAME && !got; k++) begin
            @(negedge CLK);
            if (prev_l && !lrck) got = 1;
            prev_l = lrck;
        end
        if (!got) check("lrck_fall_timeout", 0, 1);
        prev_b = bclk;
        for (int k = 0; k < 3 * FRAME && cnt < 33; k++) begin
            @(negedge CLK);
            if (!prev_b && bclk) begin
                if (cnt >= 1 && cnt <= OW) left = {left[OW-2:0], sdata};
                if (cnt > OW) right = {right[OW-2:0], sdata};
                if (cnt == 1) r1 = n;
                if (cnt == 2) r2 = n;
                cnt++;
            end
            prev_b = bclk;
        end
        if (cnt < 33) check("bclk_rise_timeout", cnt, 33);
        bclk_period = r2 - r1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [OW-1:0] left;
        logic [OW-1:0] right;
        int            per;
        int            ones;

        #1 RESET_n = 1'b0;
        #1 chk_en = 1'b1;
        check("reset_mix", mix_out, 0);
        check("reset_lrck", lrck, 0);
        repeat (3) @(negedge CLK);
        RESET_n = 1'b1;

        expect_mix("zero", 16'h0000, 1'b0);

        clear_all(); set_ch(0, 16'h1000, 4'd8);
        wait_stb();
        check("unity_mix", mix_out, 16'h1000);
        check("unity_clip", clip, 0);
        check("stb_latency", n % FRAME, 5);

        for (int ch = 0; ch < CH; ch++) set_ch(ch, 16'h7FFF, 4'd15);
        expect_mix("sat_pos", 16'h7FFF, 1'b1);
        for (int ch = 0; ch < CH; ch++) set_ch(ch, 16'h8000, 4'd15);
        expect_mix("sat_neg", 16'h8000, 1'b1);

        clear_all(); set_ch(0, 16'h2000, 4'd8); set_ch(1, 16'hF000, 4'd8);
        expect_mix("sign_sum", 16'h1000, 1'b0);
        clear_all(); set_ch(0, 16'h0003, 4'd1);
        expect_mix("floor_pos", 16'h0000, 1'b0);
        clear_all(); set_ch(0, 16'hFFFD, 4'd1);
        expect_mix("floor_neg", 16'hFFFF, 1'b0);

        clear_all(); set_ch(0, 16'hA5C3, 4'd8);
        expect_mix("i2s_word", 16'hA5C3, 1'b0);
        capture_frame(left, right, per);
        check("i2s_left", left, 16'hA5C3);
        check("i2s_right", right, 16'hA5C3);
        check("bclk_period", per, 16);

        clear_all(); set_ch(0, 16'h1234, 4'd8); set_ch(2, 16'h4000, 4'd3); mute = 1'b1;
        expect_mix("mute", 16'h0000, 1'b0);
        clear_all(); set_ch(0, 16'h1000, 4'd8);
        wait_phase(2);
        set_ch(0, 16'h7000, 4'd15);
        expect_mix("mid_acc_change", 16'h1000, 1'b0);

        for (int it = 0; it < 16; it++) begin
            repeat ($urandom_range(1, FRAME)) @(negedge CLK);
            for (int ch = 0; ch < CH; ch++) begin
                case ($urandom_range(0, 3))
                    0:       set_ch(ch, 16'h7FFF, VW'($urandom_range(0, 15)));
                    1:       set_ch(ch, 16'h8000, VW'($urandom_range(0, 15)));
                    default: set_ch(ch, INW'($urandom), VW'($urandom_range(0, 15)));
                endcase
            end
            mute = ($urandom_range(0, 7) == 0);
        end
        wait_stb();

        clear_all(); set_ch(0, 16'h5555, 4'd8); set_ch(1, 16'h1111, 4'd4);
        wait_stb();
        wait_phase(2);
        #2 RESET_n = 1'b0;
        #1;
        check("rst_mid_mix", mix_out, 0);
        check("rst_mid_stb", mix_stb, 0);
        check("rst_mid_clip", clip, 0);
        check("rst_mid_bclk", bclk, 0);
        check("rst_mid_lrck", lrck, 0);
        check("rst_mid_sdata", sdata, 0);
        repeat (2) @(negedge CLK);
        RESET_n = 1'b1;
        ones = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge CLK);
            if (sdata === 1'b1) ones++;
        end
        check("post_reset_sdata_ones", ones, 0);
        wait_stb();
        repeat (4) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
